// File: rtl/delay_pipe_credit_rx.sv
// delay_pipe_credit_rx
//   Receive end of a fixed-latency, non-backpressurable channel such as a static delay pipe.
//   Every in_vld beat is absorbed into a DEPTH-entry FIFO. The FIFO head is presented on a
//   valid/ready interface. Each consumed beat returns one registered credit pulse, so an
//   upstream transmitter that starts with DEPTH credits can never overrun the FIFO.
//
// Optional feature (compile-time macro DELAY_PIPE_CREDIT_RX_BYPASS_EN):
//   When the FIFO is empty and in_vld and out_rdy are both high, the beat is forwarded
//   combinationally from in to out and is not written into the FIFO. A credit is still
//   returned. With the macro undefined there is no in-to-out combinational path.
//
// Parameters:
//   W     data width in bits
//   DEPTH FIFO entries; equals the transmitter's initial credit count (>= 2)
//   N     upstream pipe latency, informational; full rate needs DEPTH >= N + 2
//
// Ports:
//   clk          clock
//   rst          asynchronous active-high reset
//   in           incoming data beat
//   in_vld       beat valid; cannot be backpressured
//   out          FIFO head data
//   out_vld      head valid
//   out_rdy      consumer accepts head
//   credit_r     one-cycle registered pulse per popped beat
//   overflow_r   sticky: a beat was dropped because the FIFO was full
//   occupancy_r  current entry count
module delay_pipe_credit_rx #(
  parameter int unsigned W     = 32,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned N     = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [W-1:0]               in,
  input  logic                       in_vld,
  output logic [W-1:0]               out,
  output logic                       out_vld,
  input  logic                       out_rdy,
  output logic                       credit_r,
  output logic                       overflow_r,
  output logic [$clog2(DEPTH+1)-1:0] occupancy_r
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned OccW = $clog2(DEPTH + 1);

  // N only documents the credit round trip; below N + 2 entries the link cannot stream at
  // one beat per cycle, but it remains correct.
  if (DEPTH < N + 2) begin : g_below_full_rate
  end

  logic [W-1:0]    mem [DEPTH];
  logic [PtrW-1:0] rd_ptr_q, wr_ptr_q;

  logic empty, full;
  logic bypass;
  logic pop_fifo, push_fifo, drop;

  assign empty = (occupancy_r == '0);
  assign full  = (occupancy_r == OccW'(DEPTH));

`ifdef DELAY_PIPE_CREDIT_RX_BYPASS_EN
  // Empty FIFO with a ready consumer: hand the beat straight through.
  assign bypass = empty && in_vld && out_rdy;
`else
  assign bypass = 1'b0;
`endif

  assign pop_fifo  = !empty && out_rdy;
  // A full FIFO still accepts a beat when the head leaves in the same cycle.
  assign push_fifo = in_vld && !bypass && (!full || pop_fifo);
  assign drop      = in_vld && full && !pop_fifo;

  assign out_vld = !empty || bypass;
  assign out     = bypass ? in : mem[rd_ptr_q];

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (push_fifo) begin
      mem[wr_ptr_q] <= in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      occupancy_r <= '0;
      credit_r    <= 1'b0;
      overflow_r  <= 1'b0;
    end else begin
      // Explicit wrap so non-power-of-two depths work.
      if (pop_fifo) begin
        rd_ptr_q <= (rd_ptr_q == PtrW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
      end
      if (push_fifo) begin
        wr_ptr_q <= (wr_ptr_q == PtrW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
      end
      unique case ({push_fifo, pop_fifo})
        2'b10:   occupancy_r <= occupancy_r + 1'b1;
        2'b01:   occupancy_r <= occupancy_r - 1'b1;
        default: occupancy_r <= occupancy_r;
      endcase
      credit_r <= pop_fifo || bypass;
      if (drop) begin
        overflow_r <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_delay_pipe_credit_rx.sv
// Directed bench for delay_pipe_credit_rx (W=32, DEPTH=4). A queue scoreboard holds the beats
// expected at the output; inputs change on the falling edge and outputs are sampled 2 time
// units later, well before the next rising edge.
module tb_delay_pipe_credit_rx;

  localparam int unsigned W     = 32;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned OccW  = $clog2(DEPTH + 1);

  logic            clk;
  logic            rst;
  logic [W-1:0]    in;
  logic            in_vld;
  logic [W-1:0]    out;
  logic            out_vld;
  logic            out_rdy;
  logic            credit_r;
  logic            overflow_r;
  logic [OccW-1:0] occupancy_r;

  delay_pipe_credit_rx #(
    .W     (W),
    .DEPTH (DEPTH),
    .N     (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in          (in),
    .in_vld      (in_vld),
    .out         (out),
    .out_vld     (out_vld),
    .out_rdy     (out_rdy),
    .credit_r    (credit_r),
    .overflow_r  (overflow_r),
    .occupancy_r (occupancy_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned   n_checks = 0;
  int unsigned   n_pass   = 0;
  int unsigned   n_fail   = 0;
  logic [W-1:0]  sb [$];
  logic          exp_credit = 1'b0;
  logic          exp_ovf    = 1'b0;
  int unsigned   credits_seen = 0;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_checks++;
    assert (observed === expected) begin
      n_pass++;
    end else begin
      n_fail++;
      $display("FAIL %s observed=%0h expected=%0h t=%0t", tag, observed, expected, $time);
      $error("check %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One clock cycle: drive inputs, check outputs against the scoreboard, update the model.
  // Called on a falling edge; returns on the next falling edge.
  task automatic step(input logic v, input logic [W-1:0] d, input logic r);
    logic do_pop;
    logic byp;
    in_vld  = v;
    in      = d;
    out_rdy = r;
    #2;
    byp = 1'b0;
`ifdef DELAY_PIPE_CREDIT_RX_BYPASS_EN
    byp = (sb.size() == 0) && v && r;
`endif
    if (credit_r === 1'b1) credits_seen++;
    check("credit_r", 64'(credit_r), 64'(exp_credit));
    check("overflow_r", 64'(overflow_r), 64'(exp_ovf));
    check("occupancy_r", 64'(occupancy_r), 64'(sb.size()));
    check("out_vld", 64'(out_vld), 64'((sb.size() != 0) || byp));
    if (byp) check("bypass_out", 64'(out), 64'(d));
    else if (sb.size() != 0) check("out", 64'(out), 64'(sb[0]));
    do_pop = r && (sb.size() != 0);
    if (do_pop) void'(sb.pop_front());
    if (v && !byp) begin
      if (sb.size() < DEPTH) sb.push_back(d);
      else exp_ovf = 1'b1;
    end
    exp_credit = do_pop || byp;
    @(negedge clk);
  endtask

  initial begin
    rst     = 1'b1;
    in      = '0;
    in_vld  = 1'b0;
    out_rdy = 1'b0;
    @(negedge clk);
    #2;
    // Reset state
    check("rst_out_vld", 64'(out_vld), 64'(0));
    check("rst_occupancy", 64'(occupancy_r), 64'(0));
    check("rst_credit", 64'(credit_r), 64'(0));
    check("rst_overflow", 64'(overflow_r), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    repeat (2) step(1'b0, '0, 1'b1);

    // 1: single beat, consumer always ready
    step(1'b1, 32'hDEADBEEF, 1'b1);
    repeat (3) step(1'b0, '0, 1'b1);

    // 2: fill with consumer stalled, then drain in order
    for (int i = 1; i <= 4; i++) step(1'b1, W'(i), 1'b0);
    step(1'b0, '0, 1'b0);
    check("full_occupancy", 64'(occupancy_r), 64'(4));
    repeat (6) step(1'b0, '0, 1'b1);

    // 3: overflow while full and stalled; dropped beat never appears
    for (int i = 1; i <= 4; i++) step(1'b1, W'(i), 1'b0);
    step(1'b1, 32'h5, 1'b0);
    step(1'b0, '0, 1'b0);
    check("overflow_set", 64'(overflow_r), 64'(1));
    repeat (6) step(1'b0, '0, 1'b1);
    check("overflow_sticky", 64'(overflow_r), 64'(1));

    // 4: push into a full FIFO while the head leaves
    for (int i = 1; i <= 4; i++) step(1'b1, W'(i), 1'b0);
    step(1'b1, 32'hA, 1'b1);
    step(1'b0, '0, 1'b0);
    check("pushpop_full_occ", 64'(occupancy_r), 64'(4));
    repeat (6) step(1'b0, '0, 1'b1);

    // 5: streaming 20 beats, pointers wrap
    credits_seen = 0;
    for (int i = 0; i < 20; i++) step(1'b1, W'(i), 1'b1);
    repeat (2) step(1'b0, '0, 1'b1);
    check("stream_credits", 64'(credits_seen), 64'(20));

    // 6: asynchronous reset with 3 beats held
    for (int i = 1; i <= 3; i++) step(1'b1, W'(32'h10 + i), 1'b0);
    in_vld = 1'b0;
    #2;
    check("pre_rst_occupancy", 64'(occupancy_r), 64'(3));
    rst = 1'b1;
    #1;
    check("async_rst_out_vld", 64'(out_vld), 64'(0));
    check("async_rst_occupancy", 64'(occupancy_r), 64'(0));
    check("async_rst_credit", 64'(credit_r), 64'(0));
    check("async_rst_overflow", 64'(overflow_r), 64'(0));
    sb.delete();
    exp_credit = 1'b0;
    exp_ovf    = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    step(1'b0, '0, 1'b1);
    step(1'b1, 32'h77, 1'b1);
    repeat (3) step(1'b0, '0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
